// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Signal bundle between the core's instruction-fetch port, its data port,
// the mem_arbiter and the shared SRAM controller.
//   i_*  : fetch requester (req/addr in, gnt/rvalid/rdata out of the arbiter)
//   d_*  : data requester  (req/addr/we/wdata in, gnt/rvalid/rdata out)
//   m_*  : memory side     (req/addr/we/wdata out, gnt/rvalid/rdata in)
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (core requesters + memory controller)
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // Fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  // Data port
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [BE_W-1:0]   d_we;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Memory port
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic [BE_W-1:0]   m_we;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_addr, d_we, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_addr, m_we, m_wdata,
    input  m_gnt, m_rvalid, m_rdata
  );

  modport master (
    output i_req, i_addr,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_addr, d_we, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_addr, m_we, m_wdata,
    output m_gnt, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port memory between an instruction-fetch port and a data
// port. One transaction is in flight at a time; the payload is captured into
// registers on grant and the response is routed back to the owning port.
// Data has priority, but after MAX_D_STREAK consecutive data grants while a
// fetch is waiting, the fetch wins.
// Ports:
//   clk   : clock, all state on rising edge
//   rst   : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave (fetch, data and memory handshakes)
//   busy  : a transaction is in flight (registered)
//   err   : sticky protocol error (unexpected m_rvalid or m_gnt)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic         busy,
  output logic         err
);
  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  state_e              state_q,  state_d;
  owner_e              owner_q,  owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [BE_W-1:0]     we_q,     we_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic                req_q,    req_d;
  logic                busy_q,   busy_d;
  logic                err_q,    err_d;

  logic window;
  logic d_win;
  logic i_win;

  // Arbitration window, winner selection, payload capture and next state
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    window   = 1'b0;
    d_win    = 1'b0;
    i_win    = 1'b0;

    // The window is gated by rst so no grant can be seen during reset.
    case (state_q)
      IDLE: begin
        window = rst;
      end
      REQ: begin
        if (bus.m_gnt) begin
          state_d = WAIT;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (bus.m_rvalid) begin
          window = rst;
        end else begin
          window = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (window) begin
      if (bus.d_req && (!bus.i_req || (streak_q != STREAK_MAX))) begin
        d_win   = 1'b1;
        state_d = REQ;
        owner_d = OWN_D;
        addr_d  = bus.d_addr;
        we_d    = bus.d_we;
        wdata_d = bus.d_wdata;
        // Streak only counts data grants that make a fetch wait.
        if (bus.i_req) begin
          if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_ONE;
          end else begin
            streak_d = streak_q;
          end
        end else begin
          streak_d = {STREAK_W{1'b0}};
        end
      end else if (bus.i_req) begin
        i_win    = 1'b1;
        state_d  = REQ;
        owner_d  = OWN_I;
        addr_d   = bus.i_addr;
        we_d     = {BE_W{1'b0}};
        wdata_d  = {DATA_W{1'b0}};
        streak_d = {STREAK_W{1'b0}};
      end else begin
        state_d = IDLE;
      end
    end else begin
      i_win = 1'b0;
    end
  end

  // Registered output next-state and sticky error detection
  always_comb begin
    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
    if ((bus.m_rvalid && (state_q != WAIT)) || (bus.m_gnt && (state_q != REQ))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Response routing: only the owner sees rvalid/rdata, the other port reads 0
  always_comb begin
    bus.i_rvalid = 1'b0;
    bus.i_rdata  = {DATA_W{1'b0}};
    bus.d_rvalid = 1'b0;
    bus.d_rdata  = {DATA_W{1'b0}};
    if ((state_q == WAIT) && bus.m_rvalid) begin
      if (owner_q == OWN_D) begin
        bus.d_rvalid = 1'b1;
        bus.d_rdata  = bus.m_rdata;
      end else begin
        bus.i_rvalid = 1'b1;
        bus.i_rdata  = bus.m_rdata;
      end
    end else begin
      bus.i_rvalid = 1'b0;
    end
  end

  // State and payload registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_I;
      streak_q <= {STREAK_W{1'b0}};
      addr_q   <= {ADDR_W{1'b0}};
      we_q     <= {BE_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign bus.i_gnt   = i_win;
  assign bus.d_gnt   = d_win;
  assign bus.m_req   = req_q;
  assign bus.m_addr  = addr_q;
  assign bus.m_we    = we_q;
  assign bus.m_wdata = wdata_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. A behavioural memory answers m_req with
// programmable grant / response delays; expected responses are queued when a
// request is accepted and compared when the arbiter forwards rvalid.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Memory side: either the behavioural model or manual drive
  logic        mdl_en = 1'b0;
  logic        mdl_gnt = 1'b0, mdl_rvalid = 1'b0;
  logic [31:0] mdl_rdata = 32'h0;
  logic        man_gnt = 1'b0, man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  int          gnt_delay = 0;
  int          rv_delay = 0;
  logic [31:0] mem [logic [31:0]];

  assign bus.m_gnt    = mdl_en ? mdl_gnt    : man_gnt;
  assign bus.m_rvalid = mdl_en ? mdl_rvalid : man_rvalid;
  assign bus.m_rdata  = mdl_en ? mdl_rdata  : man_rdata;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Behavioural memory: grant after gnt_delay cycles, respond rv_delay cycles later
  initial begin : mem_model
    logic        pend;
    int          gcnt, rcnt;
    logic [31:0] la, lw, old;
    logic [3:0]  lbe;
    pend = 1'b0; gcnt = 0; rcnt = 0; la = 32'h0; lw = 32'h0; lbe = 4'h0;
    forever begin
      @(posedge clk); #1;
      mdl_gnt = 1'b0; mdl_rvalid = 1'b0; mdl_rdata = 32'h0;
      if (!mdl_en) begin
        pend = 1'b0; gcnt = 0;
      end else begin
        if (pend) begin
          if (rcnt == 0) begin
            mdl_rvalid = 1'b1;
            mdl_rdata  = (lbe == 4'h0) ? mem_rd(la) : 32'h0;
            pend = 1'b0;
          end else begin
            rcnt--;
          end
        end
        if (!pend && bus.m_req) begin
          if (gcnt >= gnt_delay) begin
            mdl_gnt = 1'b1; gcnt = 0; pend = 1'b1; rcnt = rv_delay;
            la = bus.m_addr; lbe = bus.m_we; lw = bus.m_wdata;
            if (lbe != 4'h0) begin
              old = mem_rd(la);
              for (int b = 0; b < 4; b++) if (lbe[b]) old[8*b +: 8] = lw[8*b +: 8];
              mem[la] = old;
            end
          end else begin
            gcnt++;
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_addr = 32'h0; bus.d_we = 4'h0; bus.d_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0; mdl_en = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h44;
    bus.d_req = 1'b1; bus.d_addr = 32'h88; bus.d_we = 4'hF; bus.d_wdata = 32'hFFFF_FFFF;
    man_rvalid = 1'b1; man_rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_req, busy, err} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b want 0000000",
               {bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_req, busy, err});
    end
    n_cmp++;
    if ({bus.i_rdata, bus.d_rdata, bus.m_addr, bus.m_we, bus.m_wdata} !== 132'b0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0",
               {bus.i_rdata, bus.d_rdata, bus.m_addr, bus.m_we, bus.m_wdata});
    end
    idle_inputs();
    man_rvalid = 1'b0; man_rdata = 32'h0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, err, bus.m_req} !== 3'b000) begin
      n_bad++; $display("FAIL reset_release: got %b want 000", {busy, err, bus.m_req});
    end
  endtask

  task automatic test_single_fetch();
    exp_t e;
    mdl_en = 1'b1; gnt_delay = 0; rv_delay = 0;
    mem[32'h100] = 32'h0000_0013;
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    exp_q.push_back('{1'b0, 32'h0000_0013});
    @(negedge clk);
    n_cmp++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b10) begin
      n_bad++; $display("FAIL fetch_gnt: got %b want 10", {bus.i_gnt, bus.d_gnt});
    end
    @(posedge clk); #1; bus.i_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.m_req, bus.m_addr, bus.m_we, bus.m_wdata, bus.i_rvalid, bus.d_rvalid} !==
        {1'b1, 32'h100, 4'h0, 32'h0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL fetch_mreq: got req=%b addr=%h we=%h wd=%h rv=%b%b want 1 100 0 0 00",
               bus.m_req, bus.m_addr, bus.m_we, bus.m_wdata, bus.i_rvalid, bus.d_rvalid);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.i_rvalid, bus.d_rvalid} !== 2'b10) begin
      n_bad++; $display("FAIL fetch_rvalid: got %b want 10", {bus.i_rvalid, bus.d_rvalid});
    end
    if (bus.i_rvalid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++; $display("FAIL fetch_data: unexpected response %h", bus.i_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({1'b0, bus.i_rdata} !== e) begin
          n_bad++; $display("FAIL fetch_data: got %h want %h", bus.i_rdata, e.data);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, bus.i_rvalid} !== 2'b00) begin
      n_bad++; $display("FAIL fetch_done: got busy/rv %b want 00", {busy, bus.i_rvalid});
    end
  endtask

  task automatic test_store_wait();
    exp_t e;
    int   wait_cyc = 0, rv_cnt = 0;
    gnt_delay = 3; rv_delay = 0;
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_addr = 32'h203; bus.d_we = 4'b0001; bus.d_wdata = 32'hAB;
    exp_q.push_back('{1'b1, 32'h0});
    @(negedge clk);
    n_cmp++;
    if ({bus.i_gnt, bus.d_gnt} !== 2'b01) begin
      n_bad++; $display("FAIL store_gnt: got %b want 01", {bus.i_gnt, bus.d_gnt});
    end
    @(posedge clk); #1; idle_inputs();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.m_req) begin
        if (!bus.m_gnt) wait_cyc++;
        n_cmp++;
        if ({bus.m_addr, bus.m_we, bus.m_wdata} !== {32'h203, 4'b0001, 32'hAB}) begin
          n_bad++;
          $display("FAIL store_payload: got %h/%h/%h want 203/1/ab", bus.m_addr, bus.m_we, bus.m_wdata);
        end
      end
      if (bus.i_rvalid) begin
        n_cmp++; n_bad++; $display("FAIL store_irv: got i_rvalid=1 want 0");
      end
      if (bus.d_rvalid) begin
        rv_cnt++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL store_ack: unexpected d_rvalid");
        end else begin
          e = exp_q.pop_front();
          if ({1'b1, bus.d_rdata} !== e) begin
            n_bad++; $display("FAIL store_ack: got %h want %h", bus.d_rdata, e.data);
          end
        end
      end
    end
    n_cmp++;
    if (wait_cyc !== 3) begin
      n_bad++; $display("FAIL store_wait: got %0d wait cycles want 3", wait_cyc);
    end
    n_cmp++;
    if (rv_cnt !== 1) begin
      n_bad++; $display("FAIL store_rvcount: got %0d want 1", rv_cnt);
    end
    gnt_delay = 0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   stage = 0;
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_addr = 32'h203; bus.d_we = 4'h0;
    for (int c = 0; c < 30 && stage < 3; c++) begin
      @(negedge clk);
      if (bus.d_rvalid) begin
        n_cmp++;
        if (stage == 1 && bus.d_gnt !== 1'b1) begin
          n_bad++; $display("FAIL b2b_gnt: got d_gnt=%b on first d_rvalid want 1", bus.d_gnt);
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_data: unexpected d_rvalid");
        end else begin
          e = exp_q.pop_front();
          if ({1'b1, bus.d_rdata} !== e) begin
            n_bad++; $display("FAIL b2b_data: got %h want %h", bus.d_rdata, e.data);
          end
        end
        if (stage == 2) stage = 3;
      end
      if (bus.d_gnt) begin
        if (stage == 0) exp_q.push_back('{1'b1, 32'h5A5A_02AB});
        else            exp_q.push_back('{1'b1, 32'h5A5A_0204});
        stage = (stage == 0) ? 1 : 2;
        @(posedge clk); #1;
        if (stage == 1) bus.d_addr = 32'h204;
        else            bus.d_req  = 1'b0;
      end
    end
    n_cmp++;
    if (stage !== 3) begin
      n_bad++; $display("FAIL b2b_timeout: got stage %0d want 3", stage);
    end
    idle_inputs();
  endtask

  task automatic test_streak();
    exp_t        e;
    logic [9:0]  got_order = 10'h0;
    logic [9:0]  want_order = 10'b01111_01111;
    logic [31:0] ia = 32'h1000, da = 32'h2000;
    logic [65:0] got_v, want_v;
    logic        gi, gd;
    int          ng = 0;
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = ia;
    bus.d_req = 1'b1; bus.d_addr = da; bus.d_we = 4'h0;
    for (int c = 0; c < 100 && !(ng >= 10 && !busy && exp_q.size() == 0); c++) begin
      @(negedge clk);
      n_cmp++;
      if (dut.streak_q > 3'd4) begin
        n_bad++; $display("FAIL streak_bound: got %0d want <=4", dut.streak_q);
      end
      if (bus.i_rvalid || bus.d_rvalid) begin
        n_cmp++;
        got_v = {bus.d_rvalid, bus.i_rvalid, bus.i_rdata, bus.d_rdata};
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL streak_rsp: unexpected response %h", got_v);
        end else begin
          e = exp_q.pop_front();
          want_v = e.is_d ? {2'b10, 32'h0, e.data} : {2'b01, e.data, 32'h0};
          if (got_v !== want_v) begin
            n_bad++; $display("FAIL streak_rsp: got %h want %h", got_v, want_v);
          end
        end
      end
      gi = bus.i_gnt; gd = bus.d_gnt;
      if (gi && gd) begin
        n_cmp++; n_bad++; $display("FAIL streak_dualgnt: got both gnt want one");
      end
      if ((gi || gd) && ng < 10) begin
        got_order[ng] = gd;
        exp_q.push_back(gd ? '{1'b1, da ^ 32'h5A5A_0000} : '{1'b0, ia ^ 32'h5A5A_0000});
        ng++;
        @(posedge clk); #1;
        if (gd) begin da = da + 32'd4; bus.d_addr = da; end
        if (gi) begin ia = ia + 32'd4; bus.i_addr = ia; end
        if (ng >= 10) begin bus.i_req = 1'b0; bus.d_req = 1'b0; end
      end
    end
    n_cmp++;
    if (got_order !== want_order) begin
      n_bad++; $display("FAIL streak_order: got %b want %b (bit0 first, 1=D)", got_order, want_order);
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL streak_drain: got %0d pending busy=%b want 0 0", exp_q.size(), busy);
    end
    idle_inputs();
  endtask

  task automatic test_protocol_error();
    mdl_en = 1'b0;
    @(posedge clk); #1; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++;
    if ({bus.i_rvalid, bus.d_rvalid, err} !== 3'b000) begin
      n_bad++; $display("FAIL perr_drop: got rv/err %b want 000", {bus.i_rvalid, bus.d_rvalid, err});
    end
    @(posedge clk); #1; man_rvalid = 1'b0; man_rdata = 32'h0;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL perr_set: got %b want 1", err); end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL perr_sticky: got %b want 1", err); end
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL perr_clear: got %b want 0", err); end
    @(posedge clk); #1; man_gnt = 1'b1;
    @(posedge clk); #1; man_gnt = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL perr_gnt: got %b want 1", err); end
    rst = 1'b0; @(negedge clk); rst = 1'b1; @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rv_seen = 0;
    mdl_en = 1'b1; gnt_delay = 0; rv_delay = 3;
    @(posedge clk); #1; bus.i_req = 1'b1; bus.i_addr = 32'h500;
    @(negedge clk);
    n_cmp++;
    if (bus.i_gnt !== 1'b1) begin n_bad++; $display("FAIL rmid_gnt: got %b want 1", bus.i_gnt); end
    @(posedge clk); #1; bus.i_req = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy: got %b want 1", busy); end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.i_gnt, bus.d_gnt, bus.i_rvalid, bus.d_rvalid, bus.m_req, busy, err,
         bus.m_addr, bus.m_we, bus.m_wdata} !== 75'b0) begin
      n_bad++; $display("FAIL rmid_async: got busy=%b m_req=%b m_addr=%h want all 0", busy, bus.m_req, bus.m_addr);
    end
    @(negedge clk); rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_cmp++;
    if ({busy, err} !== 2'b00) begin n_bad++; $display("FAIL rmid_idle: got %b want 00", {busy, err}); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.i_rvalid || bus.d_rvalid) rv_seen++;
    end
    n_cmp++;
    if (rv_seen !== 0) begin n_bad++; $display("FAIL rmid_norv: got %0d forwarded want 0", rv_seen); end
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL rmid_err: got %b want 1", err); end
    rv_delay = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_wait();
    test_back_to_back();
    test_streak();
    test_protocol_error();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-requester arbiter that shares one single-port unified memory between the core's instruction-fetch port and data (load/store) port.
- Accepts one transaction at a time and forwards it to the memory with registered address and data. The response is routed back to the port that owns the transaction.
- Data accesses have priority. A streak counter guarantees fetch forward progress.
- Sits between the core's instruction/data memory interfaces and the shared SRAM controller.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- MAX_D_STREAK, 4, max consecutive data grants while a fetch request waits (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  ADDR_W  fetch address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  fetch read data valid
- i_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held with payload until d_gnt
- d_addr  in  ADDR_W  data address
- d_we  in  DATA_W/8  byte write enables; all-zero = read
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  data response (load data or store ack)
- d_rdata  out  DATA_W  load data
- m_req  out  1  memory request; held until m_gnt
- m_addr  out  ADDR_W  memory address (registered)
- m_we  out  DATA_W/8  memory byte enables (registered; 0 for fetch)
- m_wdata  out  DATA_W  memory write data (registered)
- m_gnt  in  1  memory accepted request
- m_rvalid  in  1  memory response, one per accepted request, ≥1 cycle after m_gnt
- m_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in flight (state ≠ IDLE)
- err  out  1  sticky protocol error flag

## Operation
- States:
  - IDLE: no transaction.
  - REQ: m_req high, waiting for m_gnt.
  - WAIT: granted, waiting for m_rvalid.
- Arbitration window: the state is IDLE, or the state is WAIT with m_rvalid=1, which allows back-to-back transactions.
- Winner selection in the window:
  - d_req only: data wins.
  - i_req only: fetch wins.
  - Both requesting: data wins unless streak == MAX_D_STREAK, in which case fetch wins.
- On a win:
  - Pulse the winner's gnt for exactly one cycle.
  - Latch the addr, we and wdata into the m_* registers. For fetch, m_we=0 and m_wdata=0.
  - Latch owner (I or D).
  - Next state is REQ.
- No request in the window: next state is IDLE.
- Streak counter, width $clog2(MAX_D_STREAK+1):
  - Increments on a data grant while i_req=1.
  - Clears on a fetch grant, or on a data grant while i_req=0.
  - Saturates at MAX_D_STREAK.
- REQ: m_req=1. On m_gnt, go to WAIT. The m_* outputs are stable throughout REQ.
- WAIT:
  - m_rvalid routes to the owner: owner_rvalid=1, owner_rdata=m_rdata (combinational). The other port's rvalid=0.
  - Non-owner rdata is driven 0.
- err is set, and stays set until reset, on:
  - m_rvalid in IDLE or REQ (the response is dropped; no rvalid is forwarded);
  - m_gnt while m_req=0.
- Requesters never see gnt and rvalid for the same transaction in the same cycle.
- Reset asserted mid-transaction aborts it immediately. The in-flight response is discarded after reset because the state is IDLE, and it sets err.

## Timing
- Reset values: state IDLE, streak 0, owner I, err 0.
- All outputs are 0 during reset: i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata, m_req, m_addr, m_we, m_wdata, busy, err.
- Cycle N: requester req=1 in the window, gnt=1.
- Cycle N+1: m_req=1 with registered payload.
- Earliest response: m_gnt at N+1, then m_rvalid at N+2. Owner rvalid at N+2, so minimum latency is 2 cycles.
- A new grant can be issued in the rvalid cycle. Sustained throughput is 1 transaction per 2 cycles with a zero-wait memory.
- gnt is a Mealy output of req and the state in the window cycle. m_* outputs are registered only.
- A request that deasserts before gnt is a requester protocol violation; the arbiter does not check it.

## Test plan
- Single fetch, zero-wait memory:
  - Stimulus: i_req, i_addr=0x100 at cycle 0; m_gnt at cycle 1; m_rvalid with m_rdata=0x00000013 at cycle 2.
  - Required: i_gnt at 0; m_req/m_addr=0x100/m_we=0 at 1; i_rvalid with i_rdata=0x13 at 2; d_rvalid=0 throughout.
- Store with wait states:
  - Stimulus: d_we=4'b0001, d_addr=0x203, d_wdata=0xAB; m_gnt delayed 3 cycles.
  - Required: m_req held 3 cycles with stable payload; d_rvalid exactly once, on m_rvalid.
- Both requesting continuously, MAX_D_STREAK=4:
  - Required: grant order D, D, D, D, I, D, D, D, D, I; the streak counter never exceeds 4.
- Back-to-back transactions:
  - Stimulus: d_req held for two transactions.
  - Required: the second d_gnt occurs in the same cycle as the first d_rvalid.
- Protocol error:
  - Stimulus: m_rvalid while IDLE.
  - Required: err=1 next cycle and stays 1; no i_rvalid or d_rvalid.
- Reset mid-operation:
  - Stimulus: rst low while in WAIT.
  - Required: all outputs 0 immediately (asynchronous); state IDLE after release; a late m_rvalid sets err.
